// File: rtl/macguffin_byte_packer.sv
// Byte-to-64-bit block packer feeding the MacGuffin core: MSB-first packing,
// PKCS#7 (or zero) padding of the final block, single-entry output register.
//
// state | meaning
// FILL  | accepting bytes into the accumulator
// FLUSH | padded final block waiting for the output register to free up
// PAD   | full-block message ended; emitting the extra 0x08 pad block
module macguffin_byte_packer #(
  parameter bit PAD_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tlast,
  output logic [63:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast
);

  typedef enum logic [1:0] {FILL, FLUSH, PAD} state_e;

  localparam logic [63:0] PAD_BLOCK = 64'h0808080808080808;

  state_e      state_q, state_d;
  logic [55:0] acc_q, acc_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [63:0] pend_q, pend_d;
  logic [63:0] out_data_q, out_data_d;
  logic        out_last_q, out_last_d;
  logic        out_valid_q, out_valid_d;

  logic        s_ready;
  logic        s_fire;
  logic        out_free;
  logic [63:0] shifted;
  logic [63:0] tail_blk;
  logic [2:0]  npad;
  logic [7:0]  pad_byte;

  assign s_ready  = (state_q == FILL) && ((cnt_q != 3'd7) || !out_valid_q);
  assign s_fire   = s_ready && s_axis_tvalid;
  assign out_free = !out_valid_q || m_axis_tready;

  // Partial final block: left-align the k received bytes, fill the rest with pad.
  always_comb begin
    npad     = 3'd7 - cnt_q;
    pad_byte = PAD_EN ? {5'd0, npad} : 8'h00;
    shifted  = {acc_q, s_axis_tdata} << {npad, 3'b000};
    tail_blk = shifted;
    for (int i = 0; i < 8; i++) begin
      if (i > int'(cnt_q)) tail_blk[63-8*i -: 8] = pad_byte;
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    pend_d      = pend_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;

    if (out_valid_q && m_axis_tready) begin
      out_valid_d = 1'b0;
      out_data_d  = '0;
      out_last_d  = 1'b0;
    end

    unique case (state_q)
      FILL: begin
        if (s_fire) begin
          if (cnt_q == 3'd7) begin
            out_data_d  = {acc_q, s_axis_tdata};
            out_valid_d = 1'b1;
            out_last_d  = s_axis_tlast && !PAD_EN;
            cnt_d       = 3'd0;
            if (s_axis_tlast && PAD_EN) state_d = PAD;
          end else if (s_axis_tlast) begin
            cnt_d = 3'd0;
            if (out_free) begin
              out_data_d  = tail_blk;
              out_valid_d = 1'b1;
              out_last_d  = 1'b1;
            end else begin
              pend_d  = tail_blk;
              state_d = FLUSH;
            end
          end else begin
            acc_d = {acc_q[47:0], s_axis_tdata};
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      FLUSH: begin
        if (out_free) begin
          out_data_d  = pend_q;
          out_valid_d = 1'b1;
          out_last_d  = 1'b1;
          cnt_d       = 3'd0;
          state_d     = FILL;
        end
      end
      PAD: begin
        if (out_free) begin
          out_data_d  = PAD_BLOCK;
          out_valid_d = 1'b1;
          out_last_d  = 1'b1;
          state_d     = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= FILL;
      acc_q       <= '0;
      cnt_q       <= '0;
      pend_q      <= '0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Ready depends on registered state only, so the input side never sees m_axis_tready.
  assign s_axis_tready = s_ready && rst;
  assign m_axis_tdata  = out_data_q;
  assign m_axis_tvalid = out_valid_q;
  assign m_axis_tlast  = out_last_q;

endmodule

// File: tb/tb_macguffin_byte_packer.sv
// Bench for macguffin_byte_packer: one instance per PAD_EN setting, a block-level
// reference model built from whole messages, and a scoreboard on the output stream.
module tb_macguffin_byte_packer;

  logic        clk;
  logic        rst;
  logic        sel;
  logic [7:0]  s_tdata;
  logic        s_tvalid;
  logic        s_tlast;
  logic        m_ready;

  logic        s_tready1, s_tready0, s_tready;
  logic [63:0] m_data1, m_data0, m_data;
  logic        m_valid1, m_valid0, m_valid;
  logic        m_last1, m_last0, m_last;

  int          checks;
  int          errors;
  int          rdy_mode;
  int          acc_cnt;
  bit          mon_en;
  logic [64:0] exp_q[$];

  macguffin_byte_packer #(.PAD_EN(1'b1)) u_dut1 (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid && sel), .s_axis_tready(s_tready1),
    .s_axis_tlast(s_tlast),
    .m_axis_tdata(m_data1), .m_axis_tvalid(m_valid1), .m_axis_tready(m_ready),
    .m_axis_tlast(m_last1)
  );

  macguffin_byte_packer #(.PAD_EN(1'b0)) u_dut0 (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid && !sel), .s_axis_tready(s_tready0),
    .s_axis_tlast(s_tlast),
    .m_axis_tdata(m_data0), .m_axis_tvalid(m_valid0), .m_axis_tready(m_ready),
    .m_axis_tlast(m_last0)
  );

  assign s_tready = sel ? s_tready1 : s_tready0;
  assign m_data   = sel ? m_data1   : m_data0;
  assign m_valid  = sel ? m_valid1  : m_valid0;
  assign m_last   = sel ? m_last1   : m_last0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: cut the message into 8-byte blocks; the tail is padded, and a
  // message of whole blocks gets an extra 0x08 block when padding is on.
  task automatic push_msg(input logic [7:0] m[$], input bit pad);
    int n = m.size();
    for (int b = 0; b < n; b += 8) begin
      logic [63:0] blk = '0;
      for (int j = 0; j < 8; j++) begin
        logic [7:0] byt;
        if (b + j < n) byt = m[b + j];
        else           byt = pad ? 8'(8 - (n - b)) : 8'h00;
        blk = {blk[55:0], byt};
      end
      exp_q.push_back({(b + 8 >= n) && !(pad && (n % 8 == 0)), blk});
    end
    if (pad && (n % 8 == 0)) exp_q.push_back({1'b1, 64'h0808080808080808});
  endtask

  task automatic send_msg(input logic [7:0] m[$], input bit with_last, input int gap_max);
    for (int i = 0; i < m.size(); i++) begin
      int  g;
      bit  done;
      g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
      s_tvalid = 1'b0;
      repeat (g) begin @(posedge clk); #1; end
      s_tdata  = m[i];
      s_tlast  = with_last && (i == m.size() - 1);
      s_tvalid = 1'b1;
      done = 1'b0;
      for (int w = 0; w < 300 && !done; w++) begin
        @(negedge clk);
        done = s_tready;
        @(posedge clk); #1;
      end
      if (!done) begin
        chk("send_timeout", {63'd0, done}, 64'd1);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        return;
      end
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic run_msg(input logic [7:0] m[$], input int gap_max);
    push_msg(m, sel);
    send_msg(m, 1'b1, gap_max);
  endtask

  task automatic drain();
    for (int w = 0; w < 1000; w++) begin
      if (exp_q.size() == 0 && !m_valid) break;
      @(posedge clk); #1;
    end
    chk("drain_left", 64'(exp_q.size()), 64'd0);
    chk("drain_valid", {63'd0, m_valid}, 64'd0);
  endtask

  // m_ready owner. 0: high, 1: random, 2: low 20 cycles then toggling, 3: low.
  initial begin
    int scnt;
    scnt = 0;
    m_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: m_ready = 1'b1;
        1: m_ready = 1'($urandom_range(0, 1));
        2: begin m_ready = (scnt >= 20) ? scnt[0] : 1'b0; scnt++; end
        default: m_ready = 1'b0;
      endcase
      if (rdy_mode != 2) scnt = 0;
    end
  end

  // Scoreboard and hold-while-stalled checker.
  initial begin
    logic        stall;
    logic [63:0] sd;
    logic        sl;
    logic [64:0] e;
    stall = 1'b0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        stall = 1'b0;
      end else begin
        if (s_tvalid && s_tready) acc_cnt++;
        if (stall) begin
          chk("hold_valid", {63'd0, m_valid}, 64'd1);
          chk("hold_data", m_data, sd);
          chk("hold_last", {63'd0, m_last}, {63'd0, sl});
        end
        if (m_valid && m_ready) begin
          chk("blk_avail", {63'd0, exp_q.size() != 0}, 64'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("blk_data", m_data, e[63:0]);
            chk("blk_last", {63'd0, m_last}, {63'd0, e[64]});
          end
        end
        stall = m_valid && !m_ready;
        sd    = m_data;
        sl    = m_last;
      end
    end
  end

  initial begin
    logic [7:0] msg[$];
    int         base;
    checks   = 0;
    errors   = 0;
    acc_cnt  = 0;
    mon_en   = 1'b0;
    rdy_mode = 0;
    sel      = 1'b1;
    rst      = 1'b0;
    s_tdata  = 8'h00;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;

    #12;
    chk("rst_s_ready", {63'd0, s_tready}, 64'd0);
    chk("rst_m_valid", {63'd0, m_valid}, 64'd0);
    chk("rst_m_data", m_data, 64'd0);
    chk("rst_m_last", {63'd0, m_last}, 64'd0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;
    chk("post_rst_ready", {63'd0, s_tready}, 64'd1);

    // Eight bytes with tlast: full block, then the pad block, ready low during PAD only.
    msg = {};
    for (int i = 0; i < 8; i++) msg.push_back(8'(i));
    run_msg(msg, 0);
    chk("full_valid", {63'd0, m_valid}, 64'd1);
    chk("full_data", m_data, 64'h0001020304050607);
    chk("pad_ready_lo", {63'd0, s_tready}, 64'd0);
    @(posedge clk); #1;
    chk("pad_data", m_data, 64'h0808080808080808);
    chk("pad_last", {63'd0, m_last}, 64'd1);
    chk("pad_ready_hi", {63'd0, s_tready}, 64'd1);
    drain();

    msg = '{8'hAA, 8'hBB, 8'hCC};
    run_msg(msg, 0);
    chk("abc_latency", {63'd0, m_valid}, 64'd1);
    chk("abc_data", m_data, 64'hAABBCC0505050505);
    drain();

    msg = '{8'h5A};
    run_msg(msg, 0);
    chk("one_data", m_data, 64'h5A07070707070707);
    msg = {};
    for (int i = 0; i < 8; i++) msg.push_back(8'(8'h10 + i));
    exp_q.push_back({1'b0, 64'h1011121314151617});
    send_msg(msg, 1'b0, 0);
    drain();

    // Backpressure: 24 bytes against a stalled then toggling sink.
    msg = {};
    for (int i = 0; i < 24; i++) msg.push_back(8'(i));
    push_msg(msg, 1'b1);
    base = acc_cnt;
    rdy_mode = 2;
    fork
      send_msg(msg, 1'b1, 0);
      begin
        repeat (19) @(posedge clk);
        #2;
        chk("stall_bytes", 64'(acc_cnt - base), 64'd15);
        chk("stall_ready", {63'd0, s_tready}, 64'd0);
      end
    join
    drain();
    rdy_mode = 0;
    drain();

    // Asynchronous reset with a block held and five bytes in flight.
    rdy_mode = 3;
    msg = {};
    for (int i = 0; i < 13; i++) msg.push_back(8'(8'h30 + i));
    send_msg(msg, 1'b0, 0);
    chk("pre_rst_valid", {63'd0, m_valid}, 64'd1);
    mon_en = 1'b0;
    #1 rst = 1'b0;
    #1;
    chk("arst_valid", {63'd0, m_valid}, 64'd0);
    chk("arst_data", m_data, 64'd0);
    chk("arst_last", {63'd0, m_last}, 64'd0);
    exp_q.delete();
    rdy_mode = 0;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;
    msg = {};
    for (int i = 0; i < 8; i++) msg.push_back(8'(8'hF0 + i));
    exp_q.push_back({1'b0, 64'hF0F1F2F3F4F5F6F7});
    send_msg(msg, 1'b0, 0);
    chk("arst_f0_data", m_data, 64'hF0F1F2F3F4F5F6F7);
    drain();

    rdy_mode = 1;
    for (int t = 0; t < 12; t++) begin
      msg = {};
      for (int i = 0; i < int'($urandom_range(1, 20)); i++) msg.push_back(8'($urandom));
      run_msg(msg, 2);
    end
    rdy_mode = 0;
    drain();

    // Zero-fill variant.
    sel = 1'b0;
    @(posedge clk); #1;
    msg = '{8'hAA, 8'hBB, 8'hCC};
    run_msg(msg, 0);
    chk("z_abc_data", m_data, 64'hAABBCC0000000000);
    chk("z_abc_last", {63'd0, m_last}, 64'd1);
    drain();
    msg = {};
    for (int i = 0; i < 8; i++) msg.push_back(8'(i));
    run_msg(msg, 0);
    chk("z_full_last", {63'd0, m_last}, 64'd1);
    chk("z_no_pad_ready", {63'd0, s_tready}, 64'd1);
    drain();
    rdy_mode = 1;
    for (int t = 0; t < 8; t++) begin
      msg = {};
      for (int i = 0; i < int'($urandom_range(1, 20)); i++) msg.push_back(8'($urandom));
      run_msg(msg, 2);
    end
    rdy_mode = 0;
    drain();
    repeat (5) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/macguffin_byte_packer.md
# macguffin_byte_packer

Upstream input stage of the MacGuffin encryption core. Accepts a byte-wide AXI-Stream message and packs it into 64-bit blocks, MSB-first. The final block is padded PKCS#7-style to a whole block. Blocks are presented on a 64-bit AXI-Stream master that connects directly to the core's `s_axis_*` port.

## Interface
- `PAD_EN`, default 1: 1 selects PKCS#7 padding; 0 zero-fills a partial final block and adds no extra block.
- `clk` in 1: single clock; all logic is rising-edge.
- `rst` in 1: reset, asynchronous, active-low. Clears all state immediately.
- `s_axis_tdata` in 8: message byte.
- `s_axis_tvalid` in 1: byte valid.
- `s_axis_tready` out 1: byte accepted when both `s_axis_tvalid` and `s_axis_tready` are high at a clock edge.
- `s_axis_tlast` in 1: marks the last byte of a message.
- `m_axis_tdata` out 64: packed block; first byte of the block is in [63:56].
- `m_axis_tvalid` out 1: block valid.
- `m_axis_tready` in 1: downstream ready.
- `m_axis_tlast` out 1: marks the final (padded) block of a message.

## Operation
- Internal state:
  - accumulator `acc` (56 bits), byte count `cnt` (0..7);
  - output register `out_data/out_last/out_valid`, which drives the `m_axis_*` outputs;
  - FSM with states FILL, FLUSH, PAD.
- `s_axis_tready` = (state == FILL) && (cnt != 7 || !out_valid). It is registered-state only, with no combinational path from `m_axis_tready`.
- FILL, byte accepted, no tlast, cnt < 7: shift the byte into `acc`; cnt++.
- FILL, byte accepted, cnt == 7 (8th byte):
  - out_data = {acc, byte}; out_valid = 1; cnt = 0.
  - If tlast and PAD_EN=1: out_last = 0; go to PAD.
  - If tlast and PAD_EN=0: out_last = 1.
  - Otherwise: out_last = 0.
- FILL, byte accepted with tlast, cnt < 7 (k = cnt+1 bytes, 1..7):
  - Form the block as the k bytes followed by (8−k) pad bytes. Each pad byte is the value (8−k) when PAD_EN=1, or 0x00 when PAD_EN=0.
  - last = 1.
  - If out_valid is low, or it is being consumed this cycle: load the output register directly; cnt = 0; stay in FILL.
  - Otherwise: hold the padded block in `acc`/pending; go to FLUSH.
- FLUSH: `s_axis_tready` = 0. Load the held block into the output register once it is empty or being consumed. cnt = 0; go to FILL.
- PAD: `s_axis_tready` = 0. Load 0x0808080808080808 with last = 1 once the output register is free; go to FILL.
- Output register:
  - Cleared when `m_axis_tvalid && m_axis_tready` and no new load occurs in the same cycle.
  - A simultaneous consume and load replaces the contents; no bubble.
- AXI rules:
  - `m_axis_tdata/tlast` are stable while tvalid is high and tready is low.
  - `m_axis_tvalid` never drops without a handshake.
- Reset, including mid-block or mid-PAD: any partial block is discarded. The next accepted byte becomes byte 0 of a new message.

## Timing
- Reset values: `s_axis_tready`=0 while rst is low, then 1 (FILL, cnt=0); `m_axis_tvalid`=0; `m_axis_tdata`=0; `m_axis_tlast`=0.
- Latency: the completing byte (8th byte, or tlast byte) is accepted at edge N; `m_axis_tvalid` is high after edge N.
- Throughput: 1 byte/cycle sustained when `m_axis_tready` is held high.
- The extra PAD block appears one cycle after the full final block is consumed, or after edge N+1 at the earliest.
- Backpressure: at cnt == 7 with a block pending, `s_axis_tready` stays low until the cycle after the block is consumed.
- Zero-length messages (tlast with no data) are impossible by construction: tlast always qualifies an actual byte.

## Test plan
- PAD_EN=1, bytes 00..07 with tlast on 07, m_ready=1:
  - first block 0x0001020304050607, tlast=0;
  - next block 0x0808080808080808, tlast=1;
  - s_tready low for exactly the PAD period.
- PAD_EN=1, bytes AA BB CC with tlast: a single block 0xAABBCC0505050505, tlast=1; output valid the cycle after CC.
- PAD_EN=1, single byte 5A with tlast: block 0x5A07070707070707, tlast=1. Then bytes 10..17 with no tlast produce 0x1011121314151617, tlast=0.
- Backpressure, 24 bytes 00..17 with tlast on 17:
  - hold m_ready low for 20 cycles, then toggle it every other cycle;
  - expect blocks 0x0001020304050607, 0x08090A0B0C0D0E0F, 0x1011121314151617, then the pad block;
  - no byte lost or duplicated; outputs stable while stalled.
- Asynchronous reset after 5 bytes of a message:
  - m_tvalid/tdata/tlast are 0 immediately, with no clock edge needed;
  - after release, 8 bytes F0..F7 produce 0xF0F1F2F3F4F5F6F7.
- PAD_EN=0:
  - AA BB CC with tlast gives 0xAABBCC0000000000, tlast=1;
  - 00..07 with tlast gives a single block 0x0001020304050607, tlast=1, with no pad block.
